// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if
//   Bundles the hazard unit's datapath-facing signals: stage register
//   indices and control bits, the data-memory wait handshake, the debugger
//   ebreak/resume pair, the per-stage stall/clear controls, status flags and
//   performance counters.
//   Modports:
//     slave  - the hazard unit (consumes datapath state, drives controls)
//     master - the datapath/debugger side
interface pipeline_hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             ebreak;
  logic             resume;
  logic [REG_W-1:0] ID_rs0;
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] EX_rs0;
  logic [REG_W-1:0] EX_rs1;
  logic [REG_W-1:0] EX_rd;
  logic [REG_W-1:0] MEM_rd;
  logic             ID_branch_type;
  logic             ID_jalr;
  logic             ID_jump;
  logic             EX_alusrc0;
  logic             EX_alusrc1;
  logic             EX_mem_write;
  logic             EX_regwrite;
  logic             EX_jal_or_jalr;
  logic             MEM_mem_to_reg;
  logic             MEM_mem_req;
  logic             mem_ready;
  logic             cnt_clr;

  logic             IF_stall;
  logic             ID_stall;
  logic             ID_clear;
  logic             EX_stall;
  logic             EX_clear;
  logic             MEM_stall;
  logic             MEM_clear;
  logic             WB_stall;
  logic             WB_clear;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  ebreak, resume, ID_rs0, ID_rs1, EX_rs0, EX_rs1, EX_rd, MEM_rd,
           ID_branch_type, ID_jalr, ID_jump, EX_alusrc0, EX_alusrc1,
           EX_mem_write, EX_regwrite, EX_jal_or_jalr, MEM_mem_to_reg,
           MEM_mem_req, mem_ready, cnt_clr,
    output IF_stall, ID_stall, ID_clear, EX_stall, EX_clear, MEM_stall,
           MEM_clear, WB_stall, WB_clear, halted, mem_timeout,
           stall_cycles, flush_count
  );

  modport master (
    output ebreak, resume, ID_rs0, ID_rs1, EX_rs0, EX_rs1, EX_rd, MEM_rd,
           ID_branch_type, ID_jalr, ID_jump, EX_alusrc0, EX_alusrc1,
           EX_mem_write, EX_regwrite, EX_jal_or_jalr, MEM_mem_to_reg,
           MEM_mem_req, mem_ready, cnt_clr,
    input  IF_stall, ID_stall, ID_clear, EX_stall, EX_clear, MEM_stall,
           MEM_clear, WB_stall, WB_clear, halted, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Stall/flush controller for a five-stage RV32I pipeline. Combinational
//   load-use and branch-operand hazard detection, a data-memory wait state
//   with timeout watchdog, a debugger halt on ebreak, and saturating
//   stall/flush performance counters.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     hz    - pipeline_hazard_unit_if.slave (all datapath/debug signals)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue; hazards resolved by stall/bubble insertion
//   WAIT  | data memory access outstanding; watchdog counting
//   HALT  | frozen for debugger (ebreak or watchdog); leaves on resume
module pipeline_hazard_unit #(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_unit_if.slave hz
);
  localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam bit WD_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wait_cnt;
  logic              to_flag;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic ex_haz, id_haz, mwait, wd_fire;
  logic if_stall, id_stall, ex_stall, mem_stall, wb_stall;
  logic id_clear, ex_clear, mem_clear, wb_clear;

  // Load-use: the loaded register is only consumed through a real register
  // operand; a store's data operand (rs1) consumes it regardless of alusrc.
  always_comb begin
    logic rs0_hit, rs1_hit;
    rs0_hit = (hz.EX_rs0 == hz.MEM_rd) && !hz.EX_alusrc0 && !hz.EX_jal_or_jalr;
    rs1_hit = (hz.EX_rs1 == hz.MEM_rd) &&
              ((!hz.EX_alusrc1 && !hz.EX_jal_or_jalr) || hz.EX_mem_write);
    ex_haz  = hz.MEM_mem_to_reg && (hz.MEM_rd != '0) && (rs0_hit || rs1_hit);
  end

  // Branch operands are resolved in ID, so any in-flight producer in EX or a
  // load in MEM blocks it. jalr only reads rs0.
  always_comb begin
    logic ex_w, mem_w, use0, use1;
    ex_w   = hz.EX_regwrite && (hz.EX_rd != '0);
    mem_w  = hz.MEM_mem_to_reg && (hz.MEM_rd != '0);
    use0   = hz.ID_branch_type || hz.ID_jalr;
    use1   = hz.ID_branch_type;
    id_haz = (use0 && ((ex_w && hz.ID_rs0 == hz.EX_rd) || (mem_w && hz.ID_rs0 == hz.MEM_rd))) ||
             (use1 && ((ex_w && hz.ID_rs1 == hz.EX_rd) || (mem_w && hz.ID_rs1 == hz.MEM_rd)));
  end

  assign mwait   = hz.MEM_mem_req && !hz.mem_ready;
  assign wd_fire = WD_EN && (state != HALT) && mwait && (wait_cnt == WC_LAST);

  always_comb begin
    state_nxt = state;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    wb_stall  = 1'b0;
    id_clear  = 1'b0;
    ex_clear  = 1'b0;
    mem_clear = 1'b0;
    wb_clear  = 1'b0;
    if (!rst_n) begin
      state_nxt = RUN;
      id_clear  = 1'b1;
      ex_clear  = 1'b1;
      mem_clear = 1'b1;
      wb_clear  = 1'b1;
    end else if (state == HALT) begin
      // A pending memory wait is ignored on the resume cycle, so a watchdog
      // halt abandons the stuck access and lets MEM advance.
      if (hz.resume) begin
        ex_clear  = 1'b1;
        state_nxt = RUN;
      end else begin
        {if_stall, id_stall, ex_stall, mem_stall, wb_stall} = '1;
      end
    end else if (mwait) begin
      {if_stall, id_stall, ex_stall, mem_stall} = '1;
      wb_clear  = 1'b1;
      state_nxt = wd_fire ? HALT : WAIT;
    end else if (hz.ebreak) begin
      {if_stall, id_stall, ex_stall, mem_stall, wb_stall} = '1;
      state_nxt = HALT;
    end else begin
      state_nxt = RUN;
      if (ex_haz) begin
        {if_stall, id_stall, ex_stall} = '1;
        mem_clear = 1'b1;
      end else if (id_haz) begin
        {if_stall, id_stall} = '1;
        ex_clear = 1'b1;
      end else if (hz.ID_jump) begin
        id_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      to_flag   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state != HALT && mwait && !wd_fire) ? wait_cnt + 1'b1 : '0;
      if (wd_fire) to_flag <= 1'b1;
      if (hz.cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (if_stall && state != HALT && stall_cnt != '1)
          stall_cnt <= stall_cnt + 1'b1;
        if ((id_clear || ex_clear || mem_clear) && flush_cnt != '1)
          flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign hz.IF_stall     = if_stall;
  assign hz.ID_stall     = id_stall;
  assign hz.EX_stall     = ex_stall;
  assign hz.MEM_stall    = mem_stall;
  assign hz.WB_stall     = wb_stall;
  assign hz.ID_clear     = id_clear;
  assign hz.EX_clear     = ex_clear;
  assign hz.MEM_clear    = mem_clear;
  assign hz.WB_clear     = wb_clear;
  // Status is masked while reset is held so it reads cleared immediately,
  // not only after the reset edge.
  assign hz.halted       = rst_n && (state == HALT);
  assign hz.mem_timeout  = rst_n && to_flag;
  assign hz.stall_cycles = rst_n ? stall_cnt : '0;
  assign hz.flush_count  = rst_n ? flush_cnt : '0;
endmodule
